// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter in front of a single-port synchronous dmem
//
// Ports:
//   clock, reset             single clock, synchronous active-high reset
//   rX_req/wren/addr/data    requester X command, held until rX_gnt
//   rX_gnt                   command issued to dmem this cycle (combinational)
//   rX_rvalid, rX_q          read return for requester X, RD_LAT cycles after grant
//   address_dmem/data/wren   dmem command port, zero when idle or in reset
//   q_dmem                   dmem read data
//   conflict_cnt             saturating count of cycles with both requests high
module dmem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,   // dmem read latency, 1 or 2
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_wren,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_data,
  input  logic              r1_req,
  input  logic              r1_wren,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_data,
  output logic              r0_gnt,
  output logic              r1_gnt,
  output logic              r0_rvalid,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r0_q,
  output logic [DATA_W-1:0] r1_q,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem,
  output logic [CNT_W-1:0]  conflict_cnt
);

  // last = port granted most recently; 1 after reset so port 0 wins the first conflict
  logic              last;
  logic              sel0;
  logic              sel1;
  logic              rd_issue;
  logic [RD_LAT-1:0] pipe_vld;
  logic [RD_LAT-1:0] pipe_id;
  logic [CNT_W-1:0]  cnt_q;

  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
    if (!reset) begin
      // port 0 wins when alone, or in conflict when port 1 was served last
      if (r0_req && (!r1_req || last)) begin
        sel0 = 1'b1;
      end else if (r1_req) begin
        sel1 = 1'b1;
      end
    end
  end

  always_comb begin
    address_dmem = '0;
    data         = '0;
    wren         = 1'b0;
    if (sel0) begin
      address_dmem = r0_addr;
      data         = r0_data;
      wren         = r0_wren;
    end else if (sel1) begin
      address_dmem = r1_addr;
      data         = r1_data;
      wren         = r1_wren;
    end
  end

  assign r0_gnt   = sel0;
  assign r1_gnt   = sel1;
  assign rd_issue = (sel0 && !r0_wren) || (sel1 && !r1_wren);

  // Read-tag pipe matches dmem latency; the tag emerging from the last stage
  // lines up with q_dmem for that read, so return order equals issue order.
  always_ff @(posedge clock) begin
    if (reset) begin
      last     <= 1'b1;
      pipe_vld <= '0;
      pipe_id  <= '0;
      cnt_q    <= '0;
    end else begin
      if (sel0 || sel1) begin
        last <= sel1;
      end
      pipe_vld[0] <= rd_issue;
      pipe_id[0]  <= sel1;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
      end
      if (r0_req && r1_req && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Gated by reset so a read landing in the reset cycle is dropped too.
  assign r0_rvalid    = !reset && pipe_vld[RD_LAT-1] && !pipe_id[RD_LAT-1];
  assign r1_rvalid    = !reset && pipe_vld[RD_LAT-1] &&  pipe_id[RD_LAT-1];
  assign r0_q         = q_dmem;
  assign r1_q         = q_dmem;
  assign conflict_cnt = reset ? '0 : cnt_q;

endmodule
